// File: rtl/dynamic_pattern_generator.sv
// Serial pattern generator.
// Holds a runtime-loaded pattern of up to PAT_W bits and streams it MSB-first
// on d_out/valid_out. The pattern is repeated a programmable number of times,
// with a programmable idle gap between repetitions. Every output is registered,
// so the first pattern bit appears one cycle after the start edge.
module dynamic_pattern_generator #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [LEN_W-1:0] pat_len,
   input  logic             start,
   input  logic [7:0]       repeat_cnt,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             d_out,
   output logic             valid_out,
   output logic             busy,
   output logic             done,
   output logic             load_err,
   output logic [7:0]       pattern_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
   localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);
   localparam logic [GAP_W-1:0] ONE_GAP = GAP_W'(1);

   state_t           state;
   logic [PAT_W-1:0] pat_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] bit_idx;
   logic [7:0]       rep_left;
   logic [GAP_W-1:0] gap_reg;
   logic [GAP_W-1:0] gap_cnt;

   logic             load_ok;
   logic [LEN_W-1:0] eff_len;
   logic [LEN_W-1:0] first_idx;
   logic [LEN_W-1:0] restart_idx;
   logic [PAT_W-1:0] pat_shift;
   logic             cur_bit;

   // Completed-repetition counter never wraps past its maximum.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Load legality, the length a same-cycle start will use, and the bit to send.
   always_comb begin
      load_ok     = pat_load && (pat_len != '0) && (pat_len <= MAX_LEN);
      eff_len     = load_ok ? pat_len : len_reg;
      first_idx   = eff_len - ONE_LEN;
      restart_idx = len_reg - ONE_LEN;
      pat_shift   = pat_reg >> bit_idx;
      cur_bit     = pat_shift[0];
   end

   // Transmit FSM with registered outputs; abort overrides every other request.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         pat_reg       <= '0;
         len_reg       <= ONE_LEN;
         bit_idx       <= '0;
         rep_left      <= '0;
         gap_reg       <= '0;
         gap_cnt       <= '0;
         d_out         <= 1'b0;
         valid_out     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         load_err      <= 1'b0;
         pattern_count <= '0;
      end else begin
         done     <= 1'b0;
         load_err <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            d_out     <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  d_out     <= 1'b0;
                  valid_out <= 1'b0;
                  if (pat_load) begin
                     if (load_ok) begin
                        pat_reg <= pat_in;
                        len_reg <= pat_len;
                     end else begin
                        load_err <= 1'b1;
                     end
                  end
                  if (start && (repeat_cnt != 8'd0)) begin
                     rep_left      <= repeat_cnt;
                     gap_reg       <= gap;
                     bit_idx       <= first_idx;
                     pattern_count <= '0;
                     busy          <= 1'b1;
                     state         <= SEND;
                  end
               end
               SEND: begin
                  d_out     <= cur_bit;
                  valid_out <= 1'b1;
                  if (bit_idx == '0) begin
                     pattern_count <= sat_inc(pattern_count);
                     rep_left      <= rep_left - 8'd1;
                     if (rep_left == 8'd1) begin
                        state <= DONE;
                     end else if (gap_reg == '0) begin
                        bit_idx <= restart_idx;
                     end else begin
                        gap_cnt <= gap_reg;
                        state   <= GAP;
                     end
                  end else begin
                     bit_idx <= bit_idx - ONE_LEN;
                  end
               end
               GAP: begin
                  d_out     <= 1'b0;
                  valid_out <= 1'b0;
                  if (gap_cnt == ONE_GAP) begin
                     bit_idx <= restart_idx;
                     state   <= SEND;
                  end else begin
                     gap_cnt <= gap_cnt - ONE_GAP;
                  end
               end
               DONE: begin
                  d_out     <= 1'b0;
                  valid_out <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dynamic_pattern_generator.sv
// Bench for dynamic_pattern_generator: directed scenarios plus randomized runs,
// each compared cycle by cycle against a stream built from the pattern rules.
module tb_dynamic_pattern_generator;

   logic       clk = 1'b0;
   logic       reset;
   logic       pat_load;
   logic [7:0] pat_in;
   logic [3:0] pat_len;
   logic       start;
   logic [7:0] repeat_cnt;
   logic [3:0] gap;
   logic       abort;
   logic       d_out;
   logic       valid_out;
   logic       busy;
   logic       done;
   logic       load_err;
   logic [7:0] pattern_count;

   int checks   = 0;
   int failures = 0;

   // Reference shadow pattern as the bench believes it is loaded.
   logic [7:0] m_pat;
   int         m_len;

   dynamic_pattern_generator #(.PAT_W(8), .LEN_W(4), .GAP_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .pat_load      (pat_load),
      .pat_in        (pat_in),
      .pat_len       (pat_len),
      .start         (start),
      .repeat_cnt    (repeat_cnt),
      .gap           (gap),
      .abort         (abort),
      .d_out         (d_out),
      .valid_out     (valid_out),
      .busy          (busy),
      .done          (done),
      .load_err      (load_err),
      .pattern_count (pattern_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check1({tag, "_d_out"}, d_out, 1'b0);
      check1({tag, "_valid"}, valid_out, 1'b0);
      check1({tag, "_busy"}, busy, 1'b0);
      check1({tag, "_done"}, done, 1'b0);
      check1({tag, "_load_err"}, load_err, 1'b0);
      check8({tag, "_count"}, pattern_count, 8'd0);
   endtask

   // mode 0: start only, 1: load then start, 2: load and start in one cycle.
   task automatic run_seq(input int mode, input logic [7:0] p, input int l,
                          input int reps, input int g);
      bit         exp_v[$];
      bit         exp_d[$];
      logic [7:0] exp_cnt;
      if (mode != 0 && l >= 1 && l <= 8) begin
         m_pat = p;
         m_len = l;
      end
      if (mode != 0) begin
         pat_load = 1'b1;
         pat_in   = p;
         pat_len  = 4'(l);
      end
      if (mode == 1) begin
         @(negedge clk);
         pat_load = 1'b0;
         check1("load_no_err", load_err, 1'b0);
      end
      start      = 1'b1;
      repeat_cnt = 8'(reps);
      gap        = 4'(g);
      @(negedge clk);
      start    = 1'b0;
      pat_load = 1'b0;
      check1("start_busy", busy, 1'b1);
      check1("start_valid", valid_out, 1'b0);
      for (int r = 0; r < reps; r++) begin
         for (int i = m_len - 1; i >= 0; i--) begin
            exp_v.push_back(1'b1);
            exp_d.push_back(m_pat[i]);
         end
         if (r < reps - 1) begin
            for (int j = 0; j < g; j++) begin
               exp_v.push_back(1'b0);
               exp_d.push_back(1'b0);
            end
         end
      end
      foreach (exp_v[n]) begin
         @(negedge clk);
         check1("stream_valid", valid_out, exp_v[n]);
         check1("stream_data", d_out, exp_d[n]);
         check1("stream_busy", busy, 1'b1);
         check1("stream_done", done, 1'b0);
      end
      exp_cnt = (reps > 255) ? 8'd255 : 8'(reps);
      @(negedge clk);
      check1("end_done", done, 1'b1);
      check1("end_busy", busy, 1'b0);
      check1("end_valid", valid_out, 1'b0);
      check8("end_count", pattern_count, exp_cnt);
      @(negedge clk);
      check1("after_done", done, 1'b0);
   endtask

   initial begin
      int l;
      int reps;
      int g;
      int mode;
      logic [7:0] p;
      bit abort_bits[5];

      reset      = 1'b0;
      pat_load   = 1'b0;
      pat_in     = '0;
      pat_len    = '0;
      start      = 1'b0;
      repeat_cnt = '0;
      gap        = '0;
      abort      = 1'b0;
      m_pat      = '0;
      m_len      = 1;

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("post_reset");

      // Back-to-back repetitions, gapped repetitions, full-width single pattern.
      run_seq(1, 8'h0B, 4, 3, 0);
      run_seq(1, 8'h0B, 4, 2, 2);
      run_seq(1, 8'hA5, 8, 1, 0);

      // Illegal lengths are rejected and leave the previous pattern in place.
      pat_load = 1'b1; pat_in = 8'h3C; pat_len = 4'd0;
      @(negedge clk);
      pat_load = 1'b0;
      check1("len0_err", load_err, 1'b1);
      @(negedge clk);
      check1("len0_err_clear", load_err, 1'b0);
      pat_load = 1'b1; pat_in = 8'h3C; pat_len = 4'd9;
      @(negedge clk);
      pat_load = 1'b0;
      check1("len9_err", load_err, 1'b1);
      @(negedge clk);
      check1("len9_err_clear", load_err, 1'b0);
      run_seq(0, 8'h00, 0, 1, 0);

      // A zero repeat count does nothing.
      start = 1'b1; repeat_cnt = 8'd0; gap = 4'd0;
      @(negedge clk);
      start = 1'b0;
      check1("rep0_busy", busy, 1'b0);
      @(negedge clk);
      check1("rep0_done", done, 1'b0);
      check1("rep0_valid", valid_out, 1'b0);

      // Abort after five bits of a 3x4 run; a load while busy is ignored.
      pat_load = 1'b1; pat_in = 8'h0B; pat_len = 4'd4;
      m_pat = 8'h0B; m_len = 4;
      @(negedge clk);
      pat_load = 1'b0;
      start = 1'b1; repeat_cnt = 8'd3; gap = 4'd0;
      @(negedge clk);
      start = 1'b0;
      abort_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int n = 0; n < 5; n++) begin
         if (n == 1) begin
            pat_load = 1'b1; pat_in = 8'hFF; pat_len = 4'd8;
         end else begin
            pat_load = 1'b0;
         end
         @(negedge clk);
         check1("abort_run_valid", valid_out, 1'b1);
         check1("abort_run_data", d_out, abort_bits[n]);
         check1("busy_load_no_err", load_err, 1'b0);
      end
      pat_load = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check1("abort_valid", valid_out, 1'b0);
      check1("abort_busy", busy, 1'b0);
      check1("abort_done", done, 1'b0);
      check8("abort_count", pattern_count, 8'd1);
      @(negedge clk);
      check1("abort_no_done", done, 1'b0);
      run_seq(0, 8'h00, 0, 1, 0);

      // Reset in the middle of a gap truncates the stream.
      run_seq(1, 8'h0B, 4, 1, 0);
      start = 1'b1; repeat_cnt = 8'd2; gap = 4'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check1("in_gap_valid", valid_out, 1'b0);
      check1("in_gap_busy", busy, 1'b1);
      check8("in_gap_count", pattern_count, 8'd1);
      #1 reset = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      repeat (3) @(negedge clk);
      check_idle_outputs("held_reset");
      reset = 1'b1;
      m_pat = 8'h00;
      m_len = 1;
      run_seq(0, 8'h00, 0, 2, 1);

      // Load and start in the same cycle use the new pattern.
      run_seq(2, 8'h06, 3, 2, 1);

      // Randomized runs.
      for (int t = 0; t < 8; t++) begin
         l    = $urandom_range(1, 8);
         p    = 8'($urandom);
         reps = $urandom_range(1, 4);
         g    = $urandom_range(0, 3);
         mode = $urandom_range(1, 2);
         run_seq(mode, p, l, reps, g);
      end

      // Maximum repeat count.
      run_seq(1, 8'h01, 1, 255, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
